// File: rtl/velocidade_display_mux_if.sv
// Speed capture interface between the speed-control logic (master) and
// the display multiplexer (slave).
//
// Signals:
//   speed_in    - binary speed, SPEED_W bits, driven by the master
//   speed_valid - capture request, driven by the master
//   speed_ready - slave is idle and will take speed_in this cycle
//
// Handshake: a transfer happens on the rising clock edge where speed_valid
// and speed_ready are both 1. The slave drops speed_valid while
// speed_ready is 0; nothing is queued. The master does not need to hold
// speed_valid until it is accepted, so a request raised while the slave
// is busy is simply lost.
interface velocidade_display_mux_if #(
    parameter int SPEED_W = 7
);
    logic [SPEED_W-1:0] speed_in;
    logic               speed_valid;
    logic               speed_ready;

    modport master (
        output speed_in,
        output speed_valid,
        input  speed_ready
    );

    modport slave (
        input  speed_in,
        input  speed_valid,
        output speed_ready
    );
endinterface

// File: rtl/velocidade_display_mux.sv
// Speed display multiplexer.
//
// Takes a binary speed value over a valid/ready interface and converts it
// to BCD one bit per clock (shift-add-3). It then scans NUM_DIGITS
// active-low 7-segment digits, blanking leading zeros. While the committed
// speed is above LIMIT, the whole display blinks.
//
// Ports:
//   clk       - system clock, all state changes on the rising edge
//   reset     - asynchronous, active-high reset
//   speed_bus - slave side of velocidade_display_mux_if
//               (speed_in, speed_valid, speed_ready)
//   seg       - segments {g,f,e,d,c,b,a}, active-low, registered
//   digit_en  - one-hot active-low digit enables, bit 0 = units, registered
//   overspeed - committed value > LIMIT, registered
//   sat       - last committed value was clamped to the display maximum
//   fsm_state - converter state (0 idle, 1 convert, 2 commit), for observation
module velocidade_display_mux #(
    parameter int SPEED_W     = 7,
    parameter int NUM_DIGITS  = 2,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SCANS = 64,
    parameter int LIMIT       = 80
) (
    input  logic                     clk,
    input  logic                     reset,
    velocidade_display_mux_if.slave  speed_bus,
    output logic [6:0]               seg,
    output logic [NUM_DIGITS-1:0]    digit_en,
    output logic                     overspeed,
    output logic                     sat,
    output logic [1:0]               fsm_state
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int MAXV  = (NUM_DIGITS == 1) ? 9 :
                           (NUM_DIGITS == 2) ? 99 :
                           (NUM_DIGITS == 3) ? 999 : 9999;
    localparam int CNT_W = $clog2(SPEED_W + 1);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RND_W = $clog2(BLINK_SCANS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t             state;
    logic               ready_q;
    logic [SPEED_W-1:0] work_bin;
    logic [BCD_W-1:0]   work_bcd;
    logic [BCD_W-1:0]   next_bcd;
    logic [CNT_W-1:0]   bit_cnt;
    logic               pend_sat;
    logic               pend_ovs;
    logic [BCD_W-1:0]   disp_bcd;

    logic [DIV_W-1:0]   div;
    logic [IDX_W-1:0]   idx;
    logic [RND_W-1:0]   rounds;
    logic               phase_on;

    logic               clamp_now;
    logic [SPEED_W-1:0] cap_val;
    logic               cap_ovs;
    logic               ovs_fall;
    logic               div_wrap;
    logic               round_wrap;

    logic [3:0]         cur_digit;
    logic               hi_zero;
    logic               blank_lead;
    logic [NUM_DIGITS-1:0] en_next;

    assign speed_bus.speed_ready = ready_q;
    assign fsm_state             = state;

    // Clamp at capture so the BCD register can never overflow.
    assign clamp_now = 32'(speed_bus.speed_in) > 32'(MAXV);
    assign cap_val   = clamp_now ? SPEED_W'(MAXV) : speed_bus.speed_in;
    assign cap_ovs   = 32'(cap_val) > 32'(LIMIT);

    // One double-dabble step: correct each nibble >= 5 by +3, then shift the
    // whole BCD word left with the next binary MSB entering at the bottom.
    // The carry out of the top nibble is always 0 thanks to the clamp.
    always_comb begin
        logic [3:0] nib;
        logic       carry;
        next_bcd = '0;
        carry    = work_bin[SPEED_W-1];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib = work_bcd[4*k +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            next_bcd[4*k +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    // Converter FSM. The display only ever sees disp_bcd, which changes
    // in COMMIT, so partial conversion results never reach the pins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            work_bin  <= '0;
            work_bcd  <= '0;
            bit_cnt   <= '0;
            pend_sat  <= 1'b0;
            pend_ovs  <= 1'b0;
            disp_bcd  <= '0;
            overspeed <= 1'b0;
            sat       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (speed_bus.speed_valid) begin
                        work_bin <= cap_val;
                        work_bcd <= '0;
                        bit_cnt  <= '0;
                        pend_sat <= clamp_now;
                        pend_ovs <= cap_ovs;
                        ready_q  <= 1'b0;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    work_bcd <= next_bcd;
                    work_bin <= work_bin << 1;
                    bit_cnt  <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(SPEED_W - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    disp_bcd  <= work_bcd;
                    overspeed <= pend_ovs;
                    sat       <= pend_sat;
                    ready_q   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ovs_fall   = (state == COMMIT) && overspeed && !pend_ovs;
    assign div_wrap   = (div == DIV_W'(SCAN_DIV - 1));
    assign round_wrap = div_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

    // Scan divider, digit index and blink phase. The blink counter runs
    // all the time; its phase only matters while overspeed is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div      <= '0;
            idx      <= '0;
            rounds   <= '0;
            phase_on <= 1'b1;
        end else begin
            if (div_wrap) begin
                div <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                div <= div + DIV_W'(1);
            end

            // Leaving overspeed restarts the blink cycle lit.
            if (ovs_fall) begin
                rounds   <= '0;
                phase_on <= 1'b1;
            end else if (round_wrap) begin
                if (rounds == RND_W'(BLINK_SCANS - 1)) begin
                    rounds   <= '0;
                    phase_on <= ~phase_on;
                end else begin
                    rounds <= rounds + RND_W'(1);
                end
            end
        end
    end

    // Select the current digit and decide on leading-zero blanking:
    // digit idx>0 is dark when it and every higher digit are zero.
    always_comb begin
        cur_digit = 4'd0;
        hi_zero   = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx) cur_digit = disp_bcd[4*k +: 4];
            if (k >= int'(idx) && disp_bcd[4*k +: 4] != 4'd0) hi_zero = 1'b0;
        end
        blank_lead = (idx != '0) && hi_zero;
        en_next    = ~(NUM_DIGITS'(1) << idx);
    end

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // Registered pin drivers: they follow the scan index one cycle late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg      <= 7'b1111111;
            digit_en <= '1;
        end else begin
            digit_en <= en_next;
            if (blank_lead || (overspeed && !phase_on)) seg <= 7'b1111111;
            else                                        seg <= seg_code(cur_digit);
        end
    end

endmodule
